// File: rtl/spi_pkg.sv
// Shared SPI types and constants: TX shifter FSM states, mode encodings and
// the default transaction length counter width.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    SHIFT     = 2'd2
  } spi_tx_state_e;

  localparam logic SPI_MODE_STD  = 1'b0;
  localparam logic SPI_MODE_QUAD = 1'b1;

  localparam int unsigned SPI_CNT_WIDTH = 16;

endpackage

// File: rtl/spi_tx_shifter.sv
// SPI TX serializer: pops words from the TX FIFO and shifts them MSB-first
// onto sdo_o, one bit (standard) or one nibble (quad) per clk_en_i tick.
// Build option: define SPI_TX_QUAD_EN to include the quad datapath; without it
// quad_i is ignored, step is 1 and sdo_o[3:1] is tied low.
module spi_tx_shifter
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = SPI_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [CNT_WIDTH-1:0]  tx_len_i,
  input  logic                  quad_i,
  input  logic                  clk_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [3:0]            sdo_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned WCW = $clog2(DATA_WIDTH) + 1;

`ifdef SPI_TX_QUAD_EN
  localparam int unsigned SDO_W = 4;
`else
  localparam int unsigned SDO_W = 1;
`endif

  spi_tx_state_e         state_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  bit_cnt_q;
  logic [WCW-1:0]        word_cnt_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [SDO_W-1:0]      sdo_q;
  logic                  done_q;

  logic [2:0]            step;
  logic [CNT_WIDTH:0]    bit_nxt;
  logic [WCW-1:0]        word_nxt;
  logic                  last_tick;
  logic                  word_end;
  logic [DATA_WIDTH-1:0] shreg_shl;
  logic [SDO_W-1:0]      load_top;
  logic [SDO_W-1:0]      shift_top;

`ifdef SPI_TX_QUAD_EN
  logic quad_q;

  assign step      = (quad_q == SPI_MODE_QUAD) ? 3'd4 : 3'd1;
  assign shreg_shl = (quad_q == SPI_MODE_QUAD) ? (shreg_q << 4) : (shreg_q << 1);
  assign load_top  = (quad_q == SPI_MODE_QUAD) ? data_i[DATA_WIDTH-1 -: 4]
                                               : {3'b000, data_i[DATA_WIDTH-1]};
  assign shift_top = (quad_q == SPI_MODE_QUAD) ? shreg_shl[DATA_WIDTH-1 -: 4]
                                               : {3'b000, shreg_shl[DATA_WIDTH-1]};
  assign sdo_o     = sdo_q;
`else
  logic unused_quad;

  assign unused_quad = quad_i;
  assign step        = 3'd1;
  assign shreg_shl   = shreg_q << 1;
  assign load_top    = data_i[DATA_WIDTH-1];
  assign shift_top   = shreg_shl[DATA_WIDTH-1];
  assign sdo_o       = {3'b000, sdo_q};
`endif

  // One bit wider than the counter so len = 2^CNT_WIDTH-1 cannot wrap.
  assign bit_nxt   = {1'b0, bit_cnt_q} + (CNT_WIDTH+1)'(step);
  assign word_nxt  = word_cnt_q + WCW'(step);
  assign last_tick = (bit_nxt >= {1'b0, len_q});
  assign word_end  = (word_nxt == WCW'(DATA_WIDTH));

  // Pop request: waiting for a word, or the tick that drains the current word
  // when the transaction still needs more bits. Never looks at valid_i.
  assign ready_o = (state_q == WAIT_DATA) ||
                   ((state_q == SHIFT) && clk_en_i && word_end && !last_tick);

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

  // Transaction FSM, counters, shift register and registered serial output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      len_q      <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shreg_q    <= '0;
      sdo_q      <= '0;
      done_q     <= 1'b0;
`ifdef SPI_TX_QUAD_EN
      quad_q     <= SPI_MODE_STD;
`endif
    end else begin
      done_q <= 1'b0;
      if (clr_i) begin
        state_q    <= IDLE;
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
        sdo_q      <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (en_i) begin
              len_q     <= tx_len_i;
              bit_cnt_q <= '0;
`ifdef SPI_TX_QUAD_EN
              quad_q    <= quad_i;
`endif
              if (tx_len_i == '0) done_q  <= 1'b1;
              else                state_q <= WAIT_DATA;
            end
          end
          WAIT_DATA: begin
            if (valid_i) begin
              shreg_q    <= data_i;
              word_cnt_q <= '0;
              sdo_q      <= load_top;
              state_q    <= SHIFT;
            end
          end
          SHIFT: begin
            if (clk_en_i) begin
              bit_cnt_q  <= bit_nxt[CNT_WIDTH-1:0];
              word_cnt_q <= word_nxt;
              if (last_tick) begin
                // Leftover low bits of the word are simply dropped.
                state_q <= IDLE;
                done_q  <= 1'b1;
                sdo_q   <= '0;
              end else if (word_end) begin
                if (valid_i) begin
                  shreg_q    <= data_i;
                  word_cnt_q <= '0;
                  sdo_q      <= load_top;
                end else begin
                  // Underrun: sdo_q keeps the last bit until the next word.
                  shreg_q <= shreg_shl;
                  state_q <= WAIT_DATA;
                end
              end else begin
                shreg_q <= shreg_shl;
                sdo_q   <= shift_top;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/spi_tx_shifter.md
# spi_tx_shifter

Transmit serializer for the SPI master. It pops 32-bit words from the TX `spi_fifo` through a valid/ready handshake and shifts them MSB-first onto the SDO lines. It supports standard (1-bit) and quad (4-bit) modes. Bit timing comes from a one-cycle `clk_en_i` tick supplied by the SPI clock generator; transaction start/end are controlled by the SPI controller FSM.

## Interface
Parameters:
- `DATA_WIDTH`, 32: FIFO word width; must be a multiple of 4.
- `CNT_WIDTH`, 16: width of the transaction bit-length field.

Ports:
- `clk_i`  in  1  system clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `clr_i`  in  1  synchronous abort; returns to IDLE
- `en_i`  in  1  start pulse, sampled in IDLE only
- `tx_len_i`  in  CNT_WIDTH  bits to send in this transaction, latched on `en_i`
- `quad_i`  in  1  0 = standard, 1 = quad; latched on `en_i`
- `clk_en_i`  in  1  shift tick, one cycle wide
- `data_i`  in  DATA_WIDTH  FIFO `data_o`
- `valid_i`  in  1  FIFO `valid_o`
- `ready_o`  out  1  pop request to FIFO `ready_i`
- `sdo_o`  out  4  serial data; `sdo_o[0]` is MOSI in standard mode
- `busy_o`  out  1  high from the cycle after `en_i` until `done_o`
- `done_o`  out  1  one-cycle pulse at transaction end

## Operation
- FSM has three states: IDLE, WAIT_DATA, SHIFT.
- IDLE:
  - On `en_i`: latch `tx_len_i` and `quad_i`, clear `bit_cnt`.
  - If `tx_len_i == 0`, pulse `done_o` next cycle and stay in IDLE; no pop occurs.
  - Otherwise go to WAIT_DATA.
- WAIT_DATA:
  - `ready_o = 1`.
  - On `valid_i`, load the shift register with `data_i`, clear `word_cnt`, go to SHIFT.
- SHIFT:
  - `sdo_o` shows the top bit (standard) or top nibble (quad) of the shift register.
  - On each `clk_en_i`: shift left by `step` (1 or 4), then add `step` to `bit_cnt` and to `word_cnt`.
- Word exhausted on a tick (`word_cnt + step == DATA_WIDTH`) and `bit_cnt + step < len`:
  - `ready_o = 1` in that same cycle.
  - If `valid_i`, load the next word seamlessly and stay in SHIFT.
  - Otherwise go to WAIT_DATA and hold `sdo_o` at its last value (underrun stall).
- Transaction end: the tick where `bit_cnt + step >= len`:
  - Pulse `done_o` next cycle and go to IDLE.
  - Remaining low bits of the current word are discarded; no extra pop.
- In quad mode, a `len` that is not a multiple of 4 rounds up to the next nibble.
- `clr_i` has priority over everything: go to IDLE, zero all counters, no `done_o` pulse.
- `en_i` outside IDLE is ignored.

## Timing
- Reset values: `sdo_o = 0`, `ready_o = 0`, `busy_o = 0`, `done_o = 0`, state IDLE, all counters 0.
- `ready_o` is combinational from state, `clk_en_i` and the counters; it never depends on `valid_i`. A pop is `ready_o && valid_i` at a `clk_i` edge.
- First bit is valid on `sdo_o` one cycle after the WAIT_DATA pop, before the first tick.
- Between tick k and tick k+1, `sdo_o` holds bit/nibble k.
- `done_o` is registered: it asserts the cycle after the final tick, while `busy_o` deasserts.
- Counter arithmetic is CNT_WIDTH-bit unsigned; `bit_cnt + step` is computed at CNT_WIDTH+1 bits to avoid wrap at `len = 2^CNT_WIDTH - 1`.
- `word_cnt` is `$clog2(DATA_WIDTH)+1` bits.
- Reset mid-transaction takes effect immediately (asynchronous); the FIFO contents are untouched.

## Configuration
- `SPI_TX_QUAD_EN` defined: quad mode available; `quad_i` selects `step` = 4.
- `SPI_TX_QUAD_EN` undefined:
  - `quad_i` is ignored and `step` is fixed at 1.
  - `sdo_o[3:1]` is tied to 0.
  - Quad datapath and its mux are not synthesized.

## Structure
- Shared package `spi_pkg`:
  - `spi_tx_state_e` enum (IDLE, WAIT_DATA, SHIFT).
  - `SPI_MODE_STD` / `SPI_MODE_QUAD` constants.
  - Default `CNT_WIDTH`.
- Single module; no sub-module. The FIFO and the clock generator are instantiated by the parent controller.

## Test plan
- `len=32`, standard, FIFO holds `0xA5000001`, tick every 4 cycles → exactly one pop; `sdo_o[0]` sequence 1,0,1,0,0,1,0,1,0…0,1; `done_o` one cycle after tick 32.
- `len=64`, quad, FIFO holds `0x12345678`, `0x9ABCDEF0` → nibbles 1…8 then 9…0 with no gap; second pop in the cycle of tick 8.
- `len=40`, standard, second word pushed 20 cycles late → stall after bit 32 with `sdo_o` held; resumes on push; 8 bits of word 2 sent, 24 discarded; 2 pops total.
- `len=0` → `done_o` the cycle after `en_i`; zero pops; `busy_o` never high.
- `clr_i` at bit 10 of a 32-bit send → IDLE next cycle, no `done_o`; a following `len=8` transaction pops a fresh word.
- `rst_ni` low mid-SHIFT → all outputs 0 immediately; FSM in IDLE after release.
